// File: rtl/vga_pkg.sv
// vga_pkg: shared timing types and standard mode constants for the VGA
// timing generator.
//   timing_cfg_t  - horizontal/vertical active, front porch, sync, back porch
//                   (TW bits each) plus sync polarities (1 = active high).
//   CFG_640x480   - 640x480 industry timing (800x525 totals, negative syncs).
//   CFG_800x600   - 800x600 timing (1056x628 totals, positive syncs).
package vga_pkg;

  localparam int TW = 12;

  typedef struct packed {
    logic [TW-1:0] h_active;
    logic [TW-1:0] h_fp;
    logic [TW-1:0] h_sync;
    logic [TW-1:0] h_bp;
    logic [TW-1:0] v_active;
    logic [TW-1:0] v_fp;
    logic [TW-1:0] v_sync;
    logic [TW-1:0] v_bp;
    logic          hs_pol;
    logic          vs_pol;
  } timing_cfg_t;

  localparam timing_cfg_t CFG_640x480 = '{
    h_active: 12'd640, h_fp: 12'd16, h_sync: 12'd96,  h_bp: 12'd48,
    v_active: 12'd480, v_fp: 12'd10, v_sync: 12'd2,   v_bp: 12'd33,
    hs_pol: 1'b0, vs_pol: 1'b0
  };

  localparam timing_cfg_t CFG_800x600 = '{
    h_active: 12'd800, h_fp: 12'd40, h_sync: 12'd128, h_bp: 12'd88,
    v_active: 12'd600, v_fp: 12'd1,  v_sync: 12'd4,   v_bp: 12'd23,
    hs_pol: 1'b1, vs_pol: 1'b1
  };

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: position counter and decode for one display axis.
//   clk, n_rst            - clock, asynchronous active-low reset
//   upd                   - pixel strobe; pos only changes when high
//   start                 - force next position to 0 (first pixel after reset)
//   adv                   - advance this axis on upd (wraps after total-1)
//   cur_*                 - timing of the frame being scanned (sets the wrap)
//   nxt_*                 - timing used to decode the next position
//   pos                   - current position
//   last                  - pos is the final position of the axis
//   nxt_in_active         - next position is inside the active region
//   nxt_in_sync           - next position is inside the sync pulse
//   nxt_last_active       - next position is the last active position
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int CW = 12
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          upd,
  input  logic          start,
  input  logic          adv,
  input  logic [CW-1:0] cur_active,
  input  logic [CW-1:0] cur_fp,
  input  logic [CW-1:0] cur_sync,
  input  logic [CW-1:0] cur_bp,
  input  logic [CW-1:0] nxt_active,
  input  logic [CW-1:0] nxt_fp,
  input  logic [CW-1:0] nxt_sync,
  input  logic [CW-1:0] nxt_bp,
  output logic [CW-1:0] pos,
  output logic          last,
  output logic          nxt_in_active,
  output logic          nxt_in_sync,
  output logic          nxt_last_active
);

  localparam int SW = CW + 2;

  logic [SW-1:0] total;
  logic [SW-1:0] sync_beg;
  logic [SW-1:0] sync_end;
  logic [SW-1:0] pos_nxt_w;
  logic [CW-1:0] pos_nxt;

  // Sums are two bits wider than a field so four maximal fields cannot overflow.
  assign total = SW'(cur_active) + SW'(cur_fp) + SW'(cur_sync) + SW'(cur_bp);
  assign last  = ({2'b00, pos} == (total - SW'(1)));

  always_comb begin
    pos_nxt = pos;
    if (start) begin
      pos_nxt = '0;
    end else if (adv) begin
      pos_nxt = last ? '0 : pos + CW'(1);
    end
  end

  // The back porch only matters for the wrap point, so nxt_bp is unused here.
  assign pos_nxt_w       = {2'b00, pos_nxt};
  assign sync_beg        = SW'(nxt_active) + SW'(nxt_fp);
  assign sync_end        = sync_beg + SW'(nxt_sync) + (SW'(nxt_bp) & '0);
  assign nxt_in_active   = (pos_nxt < nxt_active);
  assign nxt_in_sync     = (pos_nxt_w >= sync_beg) && (pos_nxt_w < sync_end);
  assign nxt_last_active = (pos_nxt == (nxt_active - CW'(1)));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pos <= '0;
    end else if (upd) begin
      pos <= pos_nxt;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: programmable VGA sync/timing generator.
//   clk, n_rst      - system clock, asynchronous active-low reset
//   cfg_valid, cfg  - new timing offer; cfg_ready high when nothing is pending
//   cfg_err         - one-clock pulse when an offered timing is rejected
//   pix_en          - one-clock strobe every CLK_DIV clocks
//   hsync, vsync    - sync outputs at the programmed polarity
//   video_on        - current pixel is in the active area
//   sof, eol        - one-clock pulses at pixel (0,0) / last active pixel of a line
//   x_coordinate,
//   y_coordinate    - current pixel position
// Config handshake: a transfer happens on a clock edge where cfg_valid and
// cfg_ready are both high. An accepted timing waits in a pending register and
// is switched in only at the frame wrap, so a frame never mixes timings.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int          CW      = 12,
  parameter int          CLK_DIV = 4,
  parameter timing_cfg_t DEF_CFG = CFG_640x480
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          cfg_valid,
  input  timing_cfg_t   cfg,
  output logic          cfg_ready,
  output logic          cfg_err,
  output logic          pix_en,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic          sof,
  output logic          eol,
  output logic [CW-1:0] x_coordinate,
  output logic [CW-1:0] y_coordinate
);

  localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW+1:0] TOT_MAX  = {2'b01, {CW{1'b0}}};

  logic [DW-1:0] div_q;
  logic [DW-1:0] div_nxt;
  logic          upd;
  logic          started_q;
  timing_cfg_t   act_q;
  timing_cfg_t   pend_cfg_q;
  logic          pend_q;
  timing_cfg_t   nxt_cfg;
  logic          xfer;
  logic          cfg_ok;
  logic [CW+1:0] off_htot;
  logic [CW+1:0] off_vtot;
  logic          frame_wrap;
  logic          apply;
  logic          h_last, v_last;
  logic          h_act_n, v_act_n;
  logic          h_sync_n, v_sync_n;
  logic          h_lact_n, v_lact_n;

  // Pixel updates happen on the edge that moves the divider to CLK_DIV-1, so
  // the clock in which pix_en is high is the one presenting the new pixel.
  assign div_nxt = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
  assign upd     = (div_nxt == DIV_LAST);

  assign off_htot = (CW+2)'(CW'(cfg.h_active)) + (CW+2)'(CW'(cfg.h_fp))
                  + (CW+2)'(CW'(cfg.h_sync)) + (CW+2)'(CW'(cfg.h_bp));
  assign off_vtot = (CW+2)'(CW'(cfg.v_active)) + (CW+2)'(CW'(cfg.v_fp))
                  + (CW+2)'(CW'(cfg.v_sync)) + (CW+2)'(CW'(cfg.v_bp));
  assign cfg_ok   = (CW'(cfg.h_active) != '0) && (CW'(cfg.v_active) != '0)
                 && (CW'(cfg.h_sync) != '0) && (CW'(cfg.v_sync) != '0)
                 && (off_htot <= TOT_MAX) && (off_vtot <= TOT_MAX);

  assign cfg_ready = ~pend_q;
  assign xfer      = cfg_valid & cfg_ready;

  // The first update after reset is treated as a frame start presenting (0,0).
  assign frame_wrap = ~started_q | (h_last & v_last);
  assign apply      = upd & frame_wrap & pend_q;
  assign nxt_cfg    = apply ? pend_cfg_q : act_q;

  vga_axis_counter #(.CW(CW)) u_h (
    .clk             (clk),
    .n_rst           (n_rst),
    .upd             (upd),
    .start           (~started_q),
    .adv             (1'b1),
    .cur_active      (CW'(act_q.h_active)),
    .cur_fp          (CW'(act_q.h_fp)),
    .cur_sync        (CW'(act_q.h_sync)),
    .cur_bp          (CW'(act_q.h_bp)),
    .nxt_active      (CW'(nxt_cfg.h_active)),
    .nxt_fp          (CW'(nxt_cfg.h_fp)),
    .nxt_sync        (CW'(nxt_cfg.h_sync)),
    .nxt_bp          (CW'(nxt_cfg.h_bp)),
    .pos             (x_coordinate),
    .last            (h_last),
    .nxt_in_active   (h_act_n),
    .nxt_in_sync     (h_sync_n),
    .nxt_last_active (h_lact_n)
  );

  vga_axis_counter #(.CW(CW)) u_v (
    .clk             (clk),
    .n_rst           (n_rst),
    .upd             (upd),
    .start           (~started_q),
    .adv             (h_last),
    .cur_active      (CW'(act_q.v_active)),
    .cur_fp          (CW'(act_q.v_fp)),
    .cur_sync        (CW'(act_q.v_sync)),
    .cur_bp          (CW'(act_q.v_bp)),
    .nxt_active      (CW'(nxt_cfg.v_active)),
    .nxt_fp          (CW'(nxt_cfg.v_fp)),
    .nxt_sync        (CW'(nxt_cfg.v_sync)),
    .nxt_bp          (CW'(nxt_cfg.v_bp)),
    .pos             (y_coordinate),
    .last            (v_last),
    .nxt_in_active   (v_act_n),
    .nxt_in_sync     (v_sync_n),
    .nxt_last_active (v_lact_n)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      div_q      <= '0;
      started_q  <= 1'b0;
      pix_en     <= 1'b0;
      act_q      <= DEF_CFG;
      pend_cfg_q <= DEF_CFG;
      pend_q     <= 1'b0;
      cfg_err    <= 1'b0;
      hsync      <= ~DEF_CFG.hs_pol;
      vsync      <= ~DEF_CFG.vs_pol;
      video_on   <= 1'b0;
      sof        <= 1'b0;
      eol        <= 1'b0;
    end else begin
      div_q   <= div_nxt;
      pix_en  <= upd;
      cfg_err <= xfer & ~cfg_ok;
      sof     <= 1'b0;
      eol     <= 1'b0;
      // apply needs pend_q high, which blocks xfer, so these never collide.
      if (xfer && cfg_ok) begin
        pend_cfg_q <= cfg;
        pend_q     <= 1'b1;
      end
      if (upd) begin
        started_q <= 1'b1;
        if (apply) begin
          act_q  <= pend_cfg_q;
          pend_q <= 1'b0;
        end
        hsync    <= nxt_cfg.hs_pol ? h_sync_n : ~h_sync_n;
        vsync    <= nxt_cfg.vs_pol ? v_sync_n : ~v_sync_n;
        video_on <= h_act_n & v_act_n;
        sof      <= frame_wrap;
        eol      <= h_lact_n & v_act_n;
      end
    end
  end

  // The last active position of the vertical axis has no output of its own.
  logic unused_ok;
  assign unused_ok = v_lact_n;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int CW  = 12;
  localparam int DIV = 2;
  localparam timing_cfg_t CFG_A = '{
    h_active: 12'd8, h_fp: 12'd2, h_sync: 12'd3, h_bp: 12'd1,
    v_active: 12'd4, v_fp: 12'd1, v_sync: 12'd2, v_bp: 12'd1,
    hs_pol: 1'b1, vs_pol: 1'b1
  };

  // ---------------- clock / reset ----------------
  logic clk;
  logic n_rst, n_rst_d;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT under CFG_A timing ----------------
  logic          cfg_valid, cfg_ready, cfg_err, pix_en, hsync, vsync;
  logic          video_on, sof, eol;
  logic [CW-1:0] x_coordinate, y_coordinate;
  timing_cfg_t   cfg;

  vga_timing_gen #(.CW(CW), .CLK_DIV(DIV), .DEF_CFG(CFG_A)) u_dut (
    .clk(clk), .n_rst(n_rst), .cfg_valid(cfg_valid), .cfg(cfg),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .pix_en(pix_en),
    .hsync(hsync), .vsync(vsync), .video_on(video_on), .sof(sof), .eol(eol),
    .x_coordinate(x_coordinate), .y_coordinate(y_coordinate)
  );

  // ---------------- DUT with default parameters ----------------
  logic          cfg_valid_d, cfg_ready_d, cfg_err_d, pix_en_d, hsync_d, vsync_d;
  logic          video_on_d, sof_d, eol_d;
  logic [CW-1:0] x_d, y_d;

  vga_timing_gen u_def (
    .clk(clk), .n_rst(n_rst_d), .cfg_valid(cfg_valid_d), .cfg(cfg),
    .cfg_ready(cfg_ready_d), .cfg_err(cfg_err_d), .pix_en(pix_en_d),
    .hsync(hsync_d), .vsync(vsync_d), .video_on(video_on_d), .sof(sof_d), .eol(eol_d),
    .x_coordinate(x_d), .y_coordinate(y_d)
  );

  logic [31:0] obs_v, obs_d;
  assign obs_v = {x_coordinate, y_coordinate, hsync, vsync, video_on, sof, eol,
                  pix_en, cfg_ready, cfg_err};
  assign obs_d = {x_d, y_d, hsync_d, vsync_d, video_on_d, sof_d, eol_d,
                  pix_en_d, cfg_ready_d, cfg_err_d};

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model (pixel-level) ----------------
  int          m_clk;
  bit          m_started, m_pend;
  int          mx, my;
  timing_cfg_t m_cfg, m_pcfg;
  logic        e_pix, e_hs, e_vs, e_von, e_sof, e_eol, e_err;
  logic [31:0] e_vec;

  function automatic int htot(timing_cfg_t c);
    return int'(c.h_active) + int'(c.h_fp) + int'(c.h_sync) + int'(c.h_bp);
  endfunction
  function automatic int vtot(timing_cfg_t c);
    return int'(c.v_active) + int'(c.v_fp) + int'(c.v_sync) + int'(c.v_bp);
  endfunction
  function automatic bit ok_cfg(timing_cfg_t c);
    return (c.h_active != 0) && (c.v_active != 0) && (c.h_sync != 0) &&
           (c.v_sync != 0) && (htot(c) <= 4096) && (vtot(c) <= 4096);
  endfunction
  function automatic timing_cfg_t rand_cfg();
    timing_cfg_t c;
    c.h_active = 12'($urandom_range(4, 10));
    c.h_fp     = 12'($urandom_range(1, 3));
    c.h_sync   = 12'($urandom_range(1, 3));
    c.h_bp     = 12'($urandom_range(1, 3));
    c.v_active = 12'($urandom_range(2, 5));
    c.v_fp     = 12'($urandom_range(1, 2));
    c.v_sync   = 12'($urandom_range(1, 2));
    c.v_bp     = 12'($urandom_range(1, 2));
    c.hs_pol   = 1'($urandom_range(0, 1));
    c.vs_pol   = 1'($urandom_range(0, 1));
    return c;
  endfunction

  task automatic model_vec();
    e_vec = {CW'(mx), CW'(my), e_hs, e_vs, e_von, e_sof, e_eol, e_pix, ~m_pend, e_err};
  endtask

  task automatic model_reset();
    m_clk = 0; m_started = 0; m_pend = 0; mx = 0; my = 0;
    m_cfg = CFG_A; m_pcfg = CFG_A;
    e_pix = 0; e_sof = 0; e_eol = 0; e_von = 0; e_err = 0;
    e_hs = ~CFG_A.hs_pol; e_vs = ~CFG_A.vs_pol;
    model_vec();
  endtask

  // Advance the model by one clock edge given the inputs present at that edge.
  task automatic model_edge(input logic v, input timing_cfg_t c);
    bit xfer, wrap, hp, vp;
    int sb;
    xfer = v && !m_pend;
    m_clk++;
    if (m_clk % DIV == DIV - 1) begin
      e_pix = 1;
      if (!m_started) begin
        mx = 0; my = 0; m_started = 1; wrap = 1;
      end else begin
        mx++;
        if (mx == htot(m_cfg)) begin
          mx = 0; my++;
          if (my == vtot(m_cfg)) my = 0;
        end
        wrap = (mx == 0) && (my == 0);
      end
      if (wrap && m_pend) begin m_cfg = m_pcfg; m_pend = 0; end
      sb = int'(m_cfg.h_active) + int'(m_cfg.h_fp);
      hp = (mx >= sb) && (mx < sb + int'(m_cfg.h_sync));
      sb = int'(m_cfg.v_active) + int'(m_cfg.v_fp);
      vp = (my >= sb) && (my < sb + int'(m_cfg.v_sync));
      e_hs  = m_cfg.hs_pol ? hp : ~hp;
      e_vs  = m_cfg.vs_pol ? vp : ~vp;
      e_von = (mx < int'(m_cfg.h_active)) && (my < int'(m_cfg.v_active));
      e_sof = wrap;
      e_eol = (mx == int'(m_cfg.h_active) - 1) && (my < int'(m_cfg.v_active));
    end else begin
      e_pix = 0; e_sof = 0; e_eol = 0;
    end
    e_err = xfer && !ok_cfg(c);
    if (xfer && ok_cfg(c)) begin m_pend = 1; m_pcfg = c; end
    model_vec();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(cfg_valid, cfg);
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_rst = 0; n_rst_d = 0; cfg_valid = 0; cfg_valid_d = 0; cfg = CFG_A;
    repeat (3) @(negedge clk);
    model_reset();
    n_checks++;
    if (obs_v !== e_vec) begin
      n_fail++; $display("FAIL reset_a actual=%h expected=%h", obs_v, e_vec);
    end
    n_checks++;
    if (obs_d !== {24'd0, 8'b1100_0010}) begin
      n_fail++; $display("FAIL reset_def actual=%h expected=%h", obs_d, {24'd0, 8'b1100_0010});
    end
    n_rst = 1; n_rst_d = 1;
  endtask

  task automatic test_frame();
    int last_sof = -1, von_cnt = 0, eol_cnt = 0;
    for (int i = 0; i < 2 * 224 + 2; i++) begin
      tick();
      n_checks++;
      if (obs_v !== e_vec) begin
        n_fail++; $display("FAIL frame_vec clk=%0d actual=%h expected=%h", m_clk, obs_v, e_vec);
      end
      if (pix_en === 1'b1) begin
        n_checks++;
        if (hsync !== (x_coordinate >= 10 && x_coordinate <= 12) ||
            vsync !== (y_coordinate >= 5 && y_coordinate <= 6)) begin
          n_fail++; $display("FAIL frame_sync x=%0d y=%0d actual=%b%b", x_coordinate,
                             y_coordinate, hsync, vsync);
        end
        if (sof === 1'b1) begin
          if (last_sof >= 0) begin
            n_checks++;
            if (i - last_sof != 224 || von_cnt != 32 || eol_cnt != 4) begin
              n_fail++;
              $display("FAIL frame_stats actual=%0d/%0d/%0d expected=224/32/4",
                       i - last_sof, von_cnt, eol_cnt);
            end
          end
          last_sof = i; von_cnt = 0; eol_cnt = 0;
        end
        if (video_on === 1'b1) von_cnt++;
        if (eol === 1'b1) begin
          eol_cnt++;
          n_checks++;
          if (x_coordinate != 7 || y_coordinate > 3) begin
            n_fail++; $display("FAIL eol_pos actual=%0d,%0d expected=7,0..3", x_coordinate, y_coordinate);
          end
        end
      end
    end
  endtask

  task automatic test_bad_cfg();
    timing_cfg_t c;
    for (int k = 0; k < 5; k++) begin
      repeat ($urandom_range(3, 40)) begin
        tick();
        n_checks++;
        if (obs_v !== e_vec) begin
          n_fail++; $display("FAIL bad_gap clk=%0d actual=%h expected=%h", m_clk, obs_v, e_vec);
        end
      end
      c = rand_cfg();
      case (k)
        0: c.h_active = 12'd0;
        1: c.v_active = 12'd0;
        2: c.h_sync   = 12'd0;
        3: c.v_sync   = 12'd0;
        default: begin c.h_fp = 12'd4000; c.h_bp = 12'($urandom_range(100, 200)); end
      endcase
      cfg = c; cfg_valid = 1;
      tick();
      cfg_valid = 0;
      n_checks++;
      if (obs_v !== e_vec || cfg_err !== 1'b1 || cfg_ready !== 1'b1) begin
        n_fail++; $display("FAIL bad_err k=%0d actual=%h expected=%h", k, obs_v, e_vec);
      end
      tick();
      n_checks++;
      if (obs_v !== e_vec || cfg_err !== 1'b0) begin
        n_fail++; $display("FAIL bad_err_clr k=%0d actual=%h expected=%h", k, obs_v, e_vec);
      end
    end
  endtask

  task automatic test_midframe();
    timing_cfg_t b;
    int guard, cnt;
    repeat ($urandom_range(30, 120)) begin
      tick();
      n_checks++;
      if (obs_v !== e_vec) begin
        n_fail++; $display("FAIL mid_pre clk=%0d actual=%h expected=%h", m_clk, obs_v, e_vec);
      end
    end
    b = rand_cfg();
    cfg = b; cfg_valid = 1;
    tick();
    n_checks++;
    if (obs_v !== e_vec || cfg_ready !== 1'b0) begin
      n_fail++; $display("FAIL mid_accept actual=%h expected=%h", obs_v, e_vec);
    end
    guard = 0;
    while (m_pend && guard < 3000) begin
      cfg = rand_cfg(); cfg_valid = 1;
      tick();
      guard++;
      n_checks++;
      if (obs_v !== e_vec) begin
        n_fail++; $display("FAIL mid_hold clk=%0d actual=%h expected=%h", m_clk, obs_v, e_vec);
      end
    end
    cfg_valid = 0;
    n_checks++;
    if (guard >= 3000 || sof !== 1'b1 || m_cfg != b) begin
      n_fail++; $display("FAIL mid_apply guard=%0d sof actual=%b required=1", guard, sof);
    end
    cnt = 0;
    do begin
      tick(); cnt++;
      n_checks++;
      if (obs_v !== e_vec) begin
        n_fail++; $display("FAIL mid_frame clk=%0d actual=%h expected=%h", m_clk, obs_v, e_vec);
      end
    end while (sof !== 1'b1 && cnt < 3000);
    n_checks++;
    if (cnt != DIV * htot(b) * vtot(b)) begin
      n_fail++; $display("FAIL mid_period actual=%0d expected=%0d", cnt, DIV * htot(b) * vtot(b));
    end
  endtask

  task automatic test_wrap_offer();
    timing_cfg_t d, old;
    int guard, cnt;
    d = rand_cfg(); old = m_cfg; guard = 0;
    while (!((m_clk + 1) % DIV == DIV - 1 && mx == htot(m_cfg) - 1 &&
             my == vtot(m_cfg) - 1) && guard < 4000) begin
      tick(); guard++;
      n_checks++;
      if (obs_v !== e_vec) begin
        n_fail++; $display("FAIL wrap_pre clk=%0d actual=%h expected=%h", m_clk, obs_v, e_vec);
      end
    end
    cfg = d; cfg_valid = 1;
    tick();
    cfg_valid = 0;
    n_checks++;
    if (guard >= 4000 || obs_v !== e_vec || sof !== 1'b1 || cfg_ready !== 1'b0) begin
      n_fail++; $display("FAIL wrap_accept actual=%h expected=%h", obs_v, e_vec);
    end
    for (int f = 0; f < 2; f++) begin
      cnt = 0;
      do begin
        tick(); cnt++;
        n_checks++;
        if (obs_v !== e_vec) begin
          n_fail++; $display("FAIL wrap_frame clk=%0d actual=%h expected=%h", m_clk, obs_v, e_vec);
        end
      end while (sof !== 1'b1 && cnt < 3000);
      n_checks++;
      if (cnt != DIV * (f == 0 ? htot(old) * vtot(old) : htot(d) * vtot(d))) begin
        n_fail++; $display("FAIL wrap_period f=%0d actual=%0d expected=%0d", f, cnt,
                           DIV * (f == 0 ? htot(old) * vtot(old) : htot(d) * vtot(d)));
      end
    end
  endtask

  task automatic test_reset_pending();
    int n, ex, ey, cidx;
    logic [31:0] exp_d;
    cfg = CFG_800x600; cfg_valid_d = 1;
    @(posedge clk); @(negedge clk);
    cfg_valid_d = 0;
    n_checks++;
    if (cfg_ready_d !== 1'b0) begin
      n_fail++; $display("FAIL def_pending actual=%b required=0", cfg_ready_d);
    end
    repeat ($urandom_range(50, 500)) @(negedge clk);
    n_rst_d = 0;
    #1;
    n_checks++;
    if (obs_d !== {24'd0, 8'b1100_0010}) begin
      n_fail++; $display("FAIL def_rst_async actual=%h expected=%h", obs_d, {24'd0, 8'b1100_0010});
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (obs_d !== {24'd0, 8'b1100_0010}) begin
      n_fail++; $display("FAIL def_rst_hold actual=%h expected=%h", obs_d, {24'd0, 8'b1100_0010});
    end
    n_rst_d = 1;
    n = 0; cidx = 0;
    while (n < 802 && cidx < 4 * 802 + 20) begin
      @(negedge clk); cidx++;
      if (pix_en_d === 1'b1) begin
        ex = n % 800; ey = n / 800;
        exp_d = {CW'(ex), CW'(ey), ~(ex >= 656 && ex < 752), 1'b1,
                 (ex < 640 && ey < 480), (n == 0), (ex == 639 && ey < 480),
                 1'b1, 1'b1, 1'b0};
        n_checks++;
        if (obs_d !== exp_d || cidx != 3 + 4 * n) begin
          n_fail++; $display("FAIL def_pixel n=%0d clk=%0d actual=%h expected=%h", n, cidx, obs_d, exp_d);
        end
        n++;
      end else if (sof_d !== 1'b0 || eol_d !== 1'b0) begin
        n_checks++; n_fail++;
        $display("FAIL def_pulse_width clk=%0d actual=%b%b required=00", cidx, sof_d, eol_d);
      end
    end
    n_checks++;
    if (n != 802) begin
      n_fail++; $display("FAIL def_strobes actual=%0d required=802", n);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_bad_cfg();
    test_midframe();
    test_wrap_offer();
    test_reset_pending();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
